multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Parametrised multicycle MIPS control unit, a clocked Moore/Mealy FSM. It sequences FETCH/DECODE/EXECUTE/MEM/WB
//  for R, I, load/store (word/half/byte), branch and jump instructions. It handshakes with a variable-latency memory
//  via mem_ready and adds a timeout, an illegal-opcode flag and a state debug output. It sits between the instruction
//  register, register file, ALU control and memory interface of the multicycle datapath.
// PARAMETERS
//  INSTR_W          32  instruction width
//  OP_LSB           26  LSB of the 6-bit opcode field: opcode = instr[OP_LSB+5:OP_LSB]
//  MEM_TIMEOUT      16  max cycles waiting on mem_ready before abort (>=1)
//  ENABLE_BYTE_HALF 1   1: lb/lh/sb/sh legal; 0: those opcodes are illegal
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        synchronous reset, active-high
//  instr         in   INSTR_W  instruction read data, sampled in FETCH
//  mem_ready     in   1        memory access complete this cycle
//  ir_write      out  1        load instruction register
//  pc_write      out  1        unconditional PC update
//  pc_write_cond out  1        PC update if branch condition true
//  branch_type   out  2        00 beq, 01 bne, 10 bgtz
//  jump          out  1        PC source = jump target
//  mem_read      out  1        memory read request
//  mem_write     out  1        memory write request
//  mem_size      out  2        00 word, 01 half, 10 byte
//  mem_to_reg    out  1        writeback from memory data
//  reg_dst       out  1        1: rd, 0: rt
//  reg_write     out  1        register file write enable
//  alu_src       out  1        1: immediate, 0: register
//  alu_op        out  3        000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//  illegal_op    out  1        one-cycle pulse: unknown opcode
//  mem_timeout   out  1        one-cycle pulse: mem_ready not seen within MEM_TIMEOUT
//  state         out  4        current state encoding (debug)
// BEHAVIOUR
//  - Reset: state=FETCH(0), opcode_q=0, wait counter=0; all outputs 0 except the FETCH defaults (mem_read=1).
//  - State updates on the clk edge only. Outputs decode from state and opcode_q. ir_write, pc_write and
//    mem_timeout are additionally qualified by mem_ready or the counter in the same cycle.
//  - Encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC_R=6 RWB=7 BRANCH=8 JUMP=9 EXEC_I=10 IWB=11.
//  - FETCH: mem_read=1. On mem_ready: ir_write=1, pc_write=1, opcode_q<=instr opcode, go to DECODE. Otherwise stay.
//  - DECODE: alu_op=000. Next state by opcode_q:
//    - lw 100011, lh 100001, lb 100000, sw 101011, sh 101001, sb 101000 -> MEMADR
//    - R-type 000000 -> EXEC_R
//    - addi 001000, andi 001100, ori 001101, slti 001010 -> EXEC_I
//    - beq 000100, bne 000101, bgtz 000111 -> BRANCH
//    - j 000010 -> JUMP
//    - else illegal_op=1, go to FETCH. lb/lh/sb/sh are illegal when ENABLE_BYTE_HALF=0.
//  - MEMADR: alu_src=1, alu_op=000. Loads -> MEMRD, stores -> MEMWR.
//  - MEMRD: mem_read=1, mem_size from opcode. On mem_ready go to MEMWB.
//  - MEMWR: mem_write=1, mem_size from opcode. On mem_ready go to FETCH.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
//  - EXEC_R: alu_op=010, alu_src=0 -> RWB. RWB: reg_write=1, reg_dst=1, alu_op=010 -> FETCH.
//  - EXEC_I: alu_src=1; alu_op 000/011/100/101 for addi/andi/ori/slti -> IWB.
//    IWB: reg_write=1, reg_dst=0, alu_src=1, same alu_op -> FETCH.
//  - BRANCH: alu_op=001, pc_write_cond=1, branch_type per opcode -> FETCH.
//  - JUMP: jump=1, pc_write=1 -> FETCH.
//  - Wait counter (width clog2(MEM_TIMEOUT+1)):
//    - cleared on every state change; increments each cycle in FETCH/MEMRD/MEMWR without mem_ready.
//    - When it equals MEM_TIMEOUT-1 and mem_ready=0: mem_timeout=1 and go to FETCH. From FETCH this restarts the fetch.
//    - No register or memory write occurs on abort.
//  - mem_ready in the same cycle as the timeout: mem_ready wins, no timeout.
//  - mem_ready outside FETCH/MEMRD/MEMWR is ignored.
//  - rst mid-operation: FETCH next cycle. A pending memory request is dropped (mem_read/mem_write follow the FETCH state).
//  - Unused outputs are 0 in every state (no X).
// TESTING
//  - lw 0x8C000000, mem_ready=1 every cycle -> states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. Total 5 cycles.
//  - add 0x00000020 -> 0,1,6,7,0. alu_op=010 in 6 and 7. reg_dst=1 and reg_write=1 only in 7.
//  - bne 0x14000000 -> BRANCH with pc_write_cond=1 and branch_type=01. j 0x08000000 -> JUMP with jump=1 and pc_write=1.
//  - sb with mem_ready held low 3 cycles in MEMWR -> mem_write=1 for 4 cycles, mem_size=10, then FETCH.
//    Repeat with ENABLE_BYTE_HALF=0 -> illegal_op pulse in DECODE.
//  - mem_ready stuck low in MEMRD, MEM_TIMEOUT=16 -> mem_timeout pulses in the 16th MEMRD cycle, then FETCH, no reg_write.
//    Opcode 0x3F -> illegal_op=1 for 1 cycle.
//  - rst=1 for 1 cycle while in EXEC_I -> next state FETCH, all write enables 0, counter 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// handshakes with a variable-latency memory and aborts stalled accesses after a timeout.
module multicycle_control #(
  parameter int unsigned INSTR_W          = 32,
  parameter int unsigned OP_LSB           = 26,
  parameter int unsigned MEM_TIMEOUT      = 16,
  parameter bit          ENABLE_BYTE_HALF = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         branch_type,
  output logic               jump,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mem_size,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src,
  output logic [2:0]         alu_op,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [3:0]         state
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBgtz  = 6'b000111;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSlti  = 6'b001010;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLh    = 6'b100001;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpSh    = 6'b101001;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [2:0] AluAdd   = 3'b000;
  localparam logic [2:0] AluSub   = 3'b001;
  localparam logic [2:0] AluFunct = 3'b010;
  localparam logic [2:0] AluAnd   = 3'b011;
  localparam logic [2:0] AluOr    = 3'b100;
  localparam logic [2:0] AluSlt   = 3'b101;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StRwb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StExecI  = 4'd10,
    StIwb    = 4'd11
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      opcode_q, opcode_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic       is_load, is_store, is_imm, is_branch;
  logic       wait_state, timeout_hit;
  logic [1:0] size_dec, btype_dec;
  logic [2:0] imm_alu;

  // Only the opcode field is consumed; the rest of the word belongs to the datapath.
  logic unused_instr;
  assign unused_instr = ^instr;

  always_comb begin
    is_load   = (opcode_q == OpLw) ||
                (ENABLE_BYTE_HALF && ((opcode_q == OpLh) || (opcode_q == OpLb)));
    is_store  = (opcode_q == OpSw) ||
                (ENABLE_BYTE_HALF && ((opcode_q == OpSh) || (opcode_q == OpSb)));
    is_imm    = (opcode_q == OpAddi) || (opcode_q == OpAndi) ||
                (opcode_q == OpOri)  || (opcode_q == OpSlti);
    is_branch = (opcode_q == OpBeq) || (opcode_q == OpBne) || (opcode_q == OpBgtz);

    // Low opcode bits separate word (x11), half (x01) and byte (x00) accesses.
    if (opcode_q[1])      size_dec = 2'b00;
    else if (opcode_q[0]) size_dec = 2'b01;
    else                  size_dec = 2'b10;

    if (opcode_q == OpBne)       btype_dec = 2'b01;
    else if (opcode_q == OpBgtz) btype_dec = 2'b10;
    else                         btype_dec = 2'b00;

    if (opcode_q == OpAndi)      imm_alu = AluAnd;
    else if (opcode_q == OpOri)  imm_alu = AluOr;
    else if (opcode_q == OpSlti) imm_alu = AluSlt;
    else                         imm_alu = AluAdd;
  end

  assign wait_state  = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // mem_ready in the final cycle takes priority over the abort.
  assign timeout_hit = wait_state && !mem_ready && (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_type   = 2'b00;
    jump          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_size      = 2'b00;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src       = 1'b0;
    alu_op        = AluAdd;
    illegal_op    = 1'b0;
    mem_timeout   = timeout_hit;

    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          opcode_d = instr[OP_LSB +: 6];
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_op = AluAdd;
        if (is_load || is_store)    state_d = StMemAdr;
        else if (opcode_q == OpRtype) state_d = StExecR;
        else if (is_imm)            state_d = StExecI;
        else if (is_branch)         state_d = StBranch;
        else if (opcode_q == OpJ)   state_d = StJump;
        else begin
          illegal_op = 1'b1;
          state_d    = StFetch;
        end
      end
      StMemAdr: begin
        alu_src = 1'b1;
        alu_op  = AluAdd;
        state_d = is_load ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        mem_size = size_dec;
        if (mem_ready)        state_d = StMemWb;
        else if (timeout_hit) state_d = StFetch;
      end
      StMemWr: begin
        mem_write = 1'b1;
        mem_size  = size_dec;
        if (mem_ready || timeout_hit) state_d = StFetch;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
        state_d    = StFetch;
      end
      StExecR: begin
        alu_op  = AluFunct;
        alu_src = 1'b0;
        state_d = StRwb;
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = AluFunct;
        state_d   = StFetch;
      end
      StExecI: begin
        alu_src = 1'b1;
        alu_op  = imm_alu;
        state_d = StIwb;
      end
      StIwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b0;
        alu_src   = 1'b1;
        alu_op    = imm_alu;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        branch_type   = btype_dec;
        state_d       = StFetch;
      end
      StJump: begin
        jump     = 1'b1;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  // A FETCH timeout keeps the same state, so the abort itself must also clear the counter.
  always_comb begin
    if ((state_d != state_q) || timeout_hit) cnt_d = '0;
    else if (wait_state && !mem_ready)       cnt_d = cnt_q + CntW'(1);
    else                                     cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      opcode_q <= 6'b000000;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  assign state = state_q;

endmodule
